// File: rtl/spm_mem_responder_if.sv
// ---------------------------------------------------------------------------
// spm_mem_responder_if
//   Bundles the four-phase req/ack memory handshake between the SPM processor
//   (master) and a memory responder (slave).
//
//   Handshake: the master raises req with we/addr/wdata stable and holds req
//   until the slave raises ack. The slave holds ack (with rdata/err valid)
//   until req falls, then drops ack on the following edge. A new access can
//   only start once ack is low again. There is no pipelining.
//
//   Signals
//     req    master->slave  access request (level)
//     we     master->slave  1 = write, 0 = read
//     addr   master->slave  word address
//     wdata  master->slave  write data
//     ack    slave->master  access complete
//     rdata  slave->master  read data, valid while ack=1 after a read
//     busy   slave->master  responder is in WAIT or ACK
//     err    slave->master  address-range error, valid while ack=1
// ---------------------------------------------------------------------------
interface spm_mem_responder_if #(
  parameter int WORD_SIZE = 8,
  parameter int ADDR_SIZE = 8
);
  logic                 req;
  logic                 we;
  logic [ADDR_SIZE-1:0] addr;
  logic [WORD_SIZE-1:0] wdata;
  logic                 ack;
  logic [WORD_SIZE-1:0] rdata;
  logic                 busy;
  logic                 err;

  modport master (
    output req, we, addr, wdata,
    input  ack, rdata, busy, err
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, rdata, busy, err
  );
endinterface

// File: rtl/spm_mem_responder.sv
// ---------------------------------------------------------------------------
// spm_mem_responder
//   Memory-side responder for the SPM processor. Completes reads and writes
//   over a four-phase req/ack handshake, with a RAM array behind a
//   programmable wait-state counter so slow memory timing can be modelled.
//
//   Parameters
//     WORD_SIZE    data width
//     ADDR_SIZE    address width
//     DEPTH        implemented words (power of 2, <= 2**ADDR_SIZE)
//     WAIT_STATES  cycles from request acceptance to ack (0..15)
//
//   Ports
//     clk        rising-edge clock
//     rst        asynchronous reset, active-low
//     bus        spm_mem_responder_if.slave (req/we/addr/wdata in,
//                ack/rdata/busy/err out)
//     state_dbg  current FSM state: 0 = IDLE, 1 = WAIT, 2 = ACK
//
//   Optional feature (macro SPM_MEM_BOUND_EN)
//     Defined:   addr >= DEPTH is out of range; writes are dropped, reads
//                return 0, and err=1 while ack is high.
//     Undefined: addr is truncated to log2(DEPTH) bits (aliasing), err=0.
//
//   Timing: the access happens on the edge that enters ACK, so ack rises
//   1+WAIT_STATES edges after (and counting) the edge that samples req=1 in
//   IDLE. Only the request fields latched in IDLE are used.
// ---------------------------------------------------------------------------
module spm_mem_responder #(
  parameter int WORD_SIZE   = 8,
  parameter int ADDR_SIZE   = 8,
  parameter int DEPTH       = 128,
  parameter int WAIT_STATES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  spm_mem_responder_if.slave   bus,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  localparam int         AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  logic [WORD_SIZE-1:0] ram [DEPTH];

  state_t               state;
  logic [3:0]           cnt;
  logic                 we_q;
  logic [ADDR_SIZE-1:0] addr_q;
  logic [WORD_SIZE-1:0] wdata_q;
  logic                 req_dropped;
  logic                 ack_r;
  logic [WORD_SIZE-1:0] rdata_r;
  logic                 busy_r;
  logic                 err_r;

  logic                 start;
  logic                 do_access;
  logic                 acc_we;
  logic [ADDR_SIZE-1:0] acc_addr;
  logic [WORD_SIZE-1:0] acc_wdata;
  logic [AW-1:0]        acc_idx;
  logic                 oob;

  // With zero wait states the access happens on the accepting edge itself,
  // so the access fields come straight from the bus in IDLE and from the
  // latched copies otherwise. Gating with rst keeps a request seen while
  // reset is held from touching the RAM.
  always_comb begin
    start     = (state == S_IDLE) && bus.req;
    do_access = rst && ((start && (WS == 4'd0)) ||
                        ((state == S_WAIT) && (cnt == 4'd1)));
    if (state == S_IDLE) begin
      acc_we    = bus.we;
      acc_addr  = bus.addr;
      acc_wdata = bus.wdata;
    end else begin
      acc_we    = we_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
    end
  end

  assign acc_idx = acc_addr[AW-1:0];

`ifdef SPM_MEM_BOUND_EN
  localparam logic [ADDR_SIZE:0] DEPTH_LIM = (ADDR_SIZE+1)'(DEPTH);
  assign oob = ({1'b0, acc_addr} >= DEPTH_LIM);
`else
  // Upper address bits are intentionally ignored (aliasing).
  logic unused_addr_hi;
  assign unused_addr_hi = ^acc_addr;
  assign oob            = 1'b0;
`endif

  // RAM contents are never reset.
  always_ff @(posedge clk) begin
    if (do_access && acc_we && !oob) begin
      ram[acc_idx] <= acc_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      cnt         <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      req_dropped <= 1'b0;
      ack_r       <= 1'b0;
      rdata_r     <= '0;
      busy_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req) begin
            we_q        <= bus.we;
            addr_q      <= bus.addr;
            wdata_q     <= bus.wdata;
            cnt         <= WS;
            req_dropped <= 1'b0;
            busy_r      <= 1'b1;
            state       <= (WS == 4'd0) ? S_ACK : S_WAIT;
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          // An early req drop still completes the access, but then ack is
          // only pulsed for a single cycle.
          if (!bus.req) begin
            req_dropped <= 1'b1;
          end
          if (cnt == 4'd1) begin
            state <= S_ACK;
          end
        end
        S_ACK: begin
          if (!bus.req || req_dropped) begin
            state  <= S_IDLE;
            ack_r  <= 1'b0;
            busy_r <= 1'b0;
            err_r  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase

      // The access itself: a write leaves rdata untouched.
      if (do_access) begin
        ack_r <= 1'b1;
        err_r <= oob;
        if (!acc_we) begin
          rdata_r <= oob ? '0 : ram[acc_idx];
        end
      end
    end
  end

  assign bus.ack   = ack_r;
  assign bus.rdata = rdata_r;
  assign bus.busy  = busy_r;
  assign bus.err   = err_r;
  assign state_dbg = state;

endmodule

// File: tb/tb_spm_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_spm_mem_responder
//   Two responders share clk/rst: dut0 with WAIT_STATES=2 and dut1 with
//   WAIT_STATES=0, both DEPTH=128. A reference model (plain arrays indexed by
//   the effective address) produces the expected {err, rdata} of each access
//   when it is issued; a monitor per DUT pops and compares on each ack rise.
//   The driver checks latency, busy, ack hold/pulse and return to IDLE.
// ---------------------------------------------------------------------------
module tb_spm_mem_responder;

  localparam int DEPTH = 128;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spm_mem_responder_if #(.WORD_SIZE(8), .ADDR_SIZE(8)) bus0 ();
  spm_mem_responder_if #(.WORD_SIZE(8), .ADDR_SIZE(8)) bus1 ();
  logic [1:0] st0, st1;

  spm_mem_responder #(.WORD_SIZE(8), .ADDR_SIZE(8), .DEPTH(DEPTH), .WAIT_STATES(2))
    dut0 (.clk(clk), .rst(rst), .bus(bus0.slave), .state_dbg(st0));
  spm_mem_responder #(.WORD_SIZE(8), .ADDR_SIZE(8), .DEPTH(DEPTH), .WAIT_STATES(0))
    dut1 (.clk(clk), .rst(rst), .bus(bus1.slave), .state_dbg(st1));

  int total = 0;
  int bad   = 0;
  int ws [2] = '{2, 0};

  // Reference model
  logic [7:0] mem_m  [2][DEPTH];
  logic [7:0] last_m [2];
  logic [8:0] exp_q0 [$];
  logic [8:0] exp_q1 [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic is_oob(input logic [7:0] a);
`ifdef SPM_MEM_BOUND_EN
    return int'(a) >= DEPTH;
`else
    return (a != a);
`endif
  endfunction

  // Returns {err, rdata} expected while ack is high.
  task automatic model_access(input int d, input logic w, input logic [7:0] a,
                              input logic [7:0] wd, output logic [8:0] e);
    logic o;
    int   idx;
    o   = is_oob(a);
    idx = int'(a) % DEPTH;
    if (w) begin
      if (!o) mem_m[d][idx] = wd;
    end else begin
      last_m[d] = o ? 8'h00 : mem_m[d][idx];
    end
    e = {o, last_m[d]};
  endtask

  task automatic drive(input int d, input logic r, input logic w,
                       input logic [7:0] a, input logic [7:0] wd);
    if (d == 0) begin
      bus0.req = r; bus0.we = w; bus0.addr = a; bus0.wdata = wd;
    end else begin
      bus1.req = r; bus1.we = w; bus1.addr = a; bus1.wdata = wd;
    end
  endtask

  // {state[1:0], busy, ack, err, rdata[7:0]}
  function automatic logic [12:0] outs(input int d);
    if (d == 0) return {st0, bus0.busy, bus0.ack, bus0.err, bus0.rdata};
    return {st1, bus1.busy, bus1.ack, bus1.err, bus1.rdata};
  endfunction

  task automatic access(input int d, input logic w, input logic [7:0] a,
                        input logic [7:0] wd, input int hold, input logic drop);
    logic [8:0]  e;
    logic [12:0] o;
    int          edges;
    logic        got;
    model_access(d, w, a, wd, e);
    if (d == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
    @(negedge clk);
    drive(d, 1'b1, w, a, wd);
    edges = 0;
    got   = 1'b0;
    o     = '0;
    while (!got && edges < 40) begin
      @(posedge clk); #1;
      edges++;
      o = outs(d);
      if (o[9]) begin
        got = 1'b1;
      end else begin
        check("busy_wait", 32'(o[10]), 32'd1);
        // Request fields change after acceptance and must be ignored.
        drive(d, !drop, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
              8'($urandom_range(0, 255)));
      end
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL ack_timeout: dut%0d no ack within 40 edges", d);
      if (d == 0) void'(exp_q0.pop_back()); else void'(exp_q1.pop_back());
      drive(d, 1'b0, 1'b0, 8'h00, 8'h00);
      return;
    end
    check("latency", 32'(edges), 32'(1 + ws[d]));
    check("busy_ack", 32'(o[10]), 32'd1);
    if (drop) begin
      @(posedge clk); #1;
      o = outs(d);
      check("pulse_ack", 32'(o[9]), 32'd0);
      check("pulse_state", 32'(o[12:11]), 32'd0);
    end else begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        o = outs(d);
        check("hold_ack", 32'(o[9]), 32'd1);
        check("hold_rdata", 32'(o[7:0]), 32'(e[7:0]));
      end
      @(negedge clk);
      drive(d, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'h00);
      @(posedge clk); #1;
      o = outs(d);
      check("release_ack", 32'(o[9]), 32'd0);
      check("release_busy", 32'(o[10]), 32'd0);
      check("release_err", 32'(o[8]), 32'd0);
      check("release_state", 32'(o[12:11]), 32'd0);
      check("release_rdata", 32'(o[7:0]), 32'(e[7:0]));
    end
  endtask

  // Monitors: compare on every rising ack.
  logic       ack_prev0 = 1'b0;
  logic       ack_prev1 = 1'b0;
  logic [8:0] e0, e1;

  always @(negedge clk) begin
    if (bus0.ack && !ack_prev0) begin
      if (exp_q0.size() == 0) begin
        total++; bad++;
        $display("FAIL mon0_unexpected: ack with empty queue rdata=%0h", bus0.rdata);
      end else begin
        e0 = exp_q0.pop_front();
        check("mon0_rdata", 32'(bus0.rdata), 32'(e0[7:0]));
        check("mon0_err", 32'(bus0.err), 32'(e0[8]));
      end
    end
    ack_prev0 = bus0.ack;
  end

  always @(negedge clk) begin
    if (bus1.ack && !ack_prev1) begin
      if (exp_q1.size() == 0) begin
        total++; bad++;
        $display("FAIL mon1_unexpected: ack with empty queue rdata=%0h", bus1.rdata);
      end else begin
        e1 = exp_q1.pop_front();
        check("mon1_rdata", 32'(bus1.rdata), 32'(e1[7:0]));
        check("mon1_err", 32'(bus1.err), 32'(e1[8]));
      end
    end
    ack_prev1 = bus1.ack;
  end

  initial begin
    logic [12:0] o;
    int          d;
    rst = 1'b0;
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    last_m[0] = 8'h00;
    last_m[1] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      o = outs(k);
      check("reset_ack", 32'(o[9]), 32'd0);
      check("reset_busy", 32'(o[10]), 32'd0);
      check("reset_err", 32'(o[8]), 32'd0);
      check("reset_rdata", 32'(o[7:0]), 32'd0);
      check("reset_state", 32'(o[12:11]), 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;

    // Fill both RAMs so every later read has a known value.
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < DEPTH; a++)
        access(k, 1'b1, 8'(a), 8'($urandom_range(0, 255)), 0, 1'b0);

    // Write then read with two wait states.
    access(0, 1'b1, 8'h03, 8'h5A, 0, 1'b0);
    access(0, 1'b0, 8'h03, 8'h00, 0, 1'b0);
    // Zero wait states: read right after write.
    access(1, 1'b1, 8'h7F, 8'hC3, 0, 1'b0);
    access(1, 1'b0, 8'h7F, 8'h00, 0, 1'b0);
    // req held past ack: no second access.
    access(0, 1'b0, 8'h03, 8'h00, 4, 1'b0);
    access(1, 1'b0, 8'h7F, 8'h00, 3, 1'b0);
    // req dropped during WAIT: access still completes, ack pulses.
    access(0, 1'b1, 8'h20, 8'h11, 0, 1'b1);
    access(0, 1'b0, 8'h20, 8'h00, 0, 1'b0);
    // Address beyond DEPTH.
    for (int k = 0; k < 2; k++) begin
      access(k, 1'b1, 8'h85, 8'hAA, 0, 1'b0);
      access(k, 1'b0, 8'h05, 8'h00, 0, 1'b0);
      access(k, 1'b0, 8'h85, 8'h00, 0, 1'b0);
    end

    // Reset in the middle of a write's WAIT phase.
    access(0, 1'b0, 8'h03, 8'h00, 0, 1'b0);
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 8'h10, ~mem_m[0][16]);
    @(posedge clk); #1;
    o = outs(0);
    check("rst_pre_state", 32'(o[12:11]), 32'd1);
    check("rst_pre_busy", 32'(o[10]), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    o = outs(0);
    check("rst_async_ack", 32'(o[9]), 32'd0);
    check("rst_async_busy", 32'(o[10]), 32'd0);
    check("rst_async_rdata", 32'(o[7:0]), 32'd0);
    check("rst_async_state", 32'(o[12:11]), 32'd0);
    o = outs(1);
    check("rst_async_rdata1", 32'(o[7:0]), 32'd0);
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    last_m[0] = 8'h00;
    last_m[1] = 8'h00;
    @(negedge clk);
    rst = 1'b1;
    access(0, 1'b0, 8'h10, 8'h00, 0, 1'b0);

    // Randomized traffic.
    repeat (120) begin
      d = int'($urandom_range(0, 1));
      access(d, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
             8'($urandom_range(0, 255)), int'($urandom_range(0, 2)),
             (d == 0) && ($urandom_range(0, 7) == 0));
    end

    repeat (3) @(posedge clk);
    #1;
    check("q0_drained", 32'(exp_q0.size()), 32'd0);
    check("q1_drained", 32'(exp_q1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
